// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the HC-SR04 style ultrasonic ranger.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_ECHO,
    MEASURE,
    HOLDOFF
  } ranger_state_t;

  localparam logic [2:0] DIST_NONE = 3'd0;
  localparam logic [2:0] DIST_BIN1 = 3'd1;
  localparam logic [2:0] DIST_BIN2 = 3'd2;
  localparam logic [2:0] DIST_BIN3 = 3'd3;
  localparam logic [2:0] DIST_BIN4 = 3'd4;

  localparam logic [8:0] CM_MAX = 9'd511;

  // Quantise a distance to its bin code; a timeout always maps to DIST_NONE.
  function automatic logic [2:0] cm_to_bin(input logic [8:0] cm, input logic timeout,
                                           input int th1, input int th2,
                                           input int th3, input int th4);
    int c;
    c = int'(cm);
    if (timeout)       return DIST_NONE;
    else if (c < th1)  return DIST_BIN1;
    else if (c < th2)  return DIST_BIN2;
    else if (c < th3)  return DIST_BIN3;
    else if (c < th4)  return DIST_BIN4;
    else               return DIST_NONE;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor and controller-facing signals of the ultrasonic ranger.
interface ultrasonic_ranger_if;
  logic       ctrl;
  logic       echo;
  logic       trigger;
  logic [2:0] distance_output;
  logic [8:0] distance_cm;
  logic       distance_valid;

  modport master (
    output ctrl, echo,
    input  trigger, distance_output, distance_cm, distance_valid
  );

  modport slave (
    input  ctrl, echo,
    output trigger, distance_output, distance_cm, distance_valid
  );
endinterface

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Two-flop synchroniser for the echo line, plus a third flop for edge detection.
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [2:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[1:0], async_in};

  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/ultrasonic_ranger.sv
// Trigger/echo sequencer: times the echo pulse in centimetres and bins the result.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_CYCLES    = 1000,
  parameter int CYCLES_PER_CM  = 5800,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int HOLDOFF_CYCLES = 6000000,
  parameter int TH1_CM         = 10,
  parameter int TH2_CM         = 20,
  parameter int TH3_CM         = 30,
  parameter int TH4_CM         = 40
) (
  input  logic               clk,
  input  logic               reset,
  ultrasonic_ranger_if.slave rif
);
  localparam int MAX_A   = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > HOLDOFF_CYCLES) ? MAX_A : HOLDOFF_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int SW      = $clog2(CYCLES_PER_CM) + 1;

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(HOLDOFF_CYCLES);
  localparam logic [SW-1:0] SUB_LAST  = SW'(CYCLES_PER_CM - 1);

  ranger_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [8:0]    cm_q, cm_d;
  logic          trigger_q, trigger_d;
  logic [2:0]    dout_q, dout_d;
  logic [8:0]    dcm_q, dcm_d;
  logic          valid_q, valid_d;

  logic       echo_lvl, echo_rise, echo_fall;
  logic       load, load_to;
  logic [8:0] load_cm;

  echo_sync u_echo_sync (
    .clk     (clk),
    .reset   (reset),
    .async_in(rif.echo),
    .level   (echo_lvl),
    .rise    (echo_rise),
    .fall    (echo_fall)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    dout_d  = dout_q;
    dcm_d   = dcm_q;
    valid_d = 1'b0;
    load    = 1'b0;
    load_to = 1'b0;
    load_cm = cm_q;

    case (state_q)
      IDLE: begin
        if (rif.ctrl) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end
      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_ECHO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_ECHO: begin
        // Only an edge starts a measurement, so a stale high level must fall first.
        // The rise cycle is itself the first high cycle, hence the preload of 1.
        if (echo_rise) begin
          state_d = MEASURE;
          cnt_d   = CW'(1);
          sub_d   = SW'(1);
          cm_d    = '0;
        end else if (cnt_q == TO_LAST) begin
          load    = 1'b1;
          load_to = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          load = 1'b1;
        end else if (echo_lvl) begin
          if (cnt_q == TO_LAST) begin
            load    = 1'b1;
            load_to = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (sub_q == SUB_LAST) begin
              sub_d = '0;
              if (cm_q != CM_MAX) cm_d = cm_q + 1'b1;
            end else begin
              sub_d = sub_q + 1'b1;
            end
          end
        end
      end
      HOLDOFF: begin
        if (cnt_q == HOLD_END) begin
          state_d = rif.ctrl ? TRIG : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (load) begin
      state_d = HOLDOFF;
      cnt_d   = '0;
      valid_d = 1'b1;
      dcm_d   = load_to ? CM_MAX : load_cm;
      dout_d  = cm_to_bin(load_cm, load_to, TH1_CM, TH2_CM, TH3_CM, TH4_CM);
    end

    // Dropping ctrl abandons the shot without touching the last published result.
    if (state_q != IDLE && !rif.ctrl) begin
      state_d = IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      dout_d  = dout_q;
      dcm_d   = dcm_q;
    end

    trigger_d = (state_d == TRIG);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sub_q     <= '0;
      cm_q      <= '0;
      trigger_q <= 1'b0;
      dout_q    <= DIST_NONE;
      dcm_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      cm_q      <= cm_d;
      trigger_q <= trigger_d;
      dout_q    <= dout_d;
      dcm_q     <= dcm_d;
      valid_q   <= valid_d;
    end
  end

  assign rif.trigger         = trigger_q;
  assign rif.distance_output = dout_q;
  assign rif.distance_cm     = dcm_q;
  assign rif.distance_valid  = valid_q;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: table of echo widths plus hand-written corner sequences.
module tb_ultrasonic_ranger;
  localparam int TRIG = 5;
  localparam int CPC  = 4;
  localparam int TO   = 400;
  localparam int HO   = 50;

  typedef struct {
    int len;
    int exp_cm;
    int exp_bin;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   nvec  = 0;
  int   nfail = 0;

  ultrasonic_ranger_if rif();

  ultrasonic_ranger #(
    .TRIG_CYCLES   (TRIG),
    .CYCLES_PER_CM (CPC),
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rif  (rif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", nvec);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits until trigger (sel_valid=0) or distance_valid (sel_valid=1) equals val.
  task automatic wait_for(input string name, input bit sel_valid, input logic val,
                          input int max, output int n);
    logic s;
    n = 0;
    s = sel_valid ? rif.distance_valid : rif.trigger;
    while (s !== val && n < max) begin
      tick();
      n++;
      s = sel_valid ? rif.distance_valid : rif.trigger;
    end
    if (s !== val) begin
      nvec++;
      nfail++;
      $display("FAIL %s: got no event in %0d cycles, expected one", name, max);
      n = -1;
    end
  endtask

  task automatic start_shot();
    int n;
    rif.ctrl = 1'b1;
    wait_for("trigger rise", 1'b0, 1'b1, 10, n);
    wait_for("trigger fall", 1'b0, 1'b0, 20, n);
  endtask

  initial begin
    vec_t vecs[9];
    int   n, len, vcnt, tcnt;

    vecs[0] = '{60, 15, 2};
    vecs[1] = '{40, 10, 2};
    vecs[2] = '{39, 9, 1};
    vecs[3] = '{160, 40, 0};
    vecs[4] = '{4, 1, 1};
    vecs[5] = '{3, 0, 1};
    vecs[6] = '{120, 30, 4};
    vecs[7] = '{119, 29, 3};
    vecs[8] = '{80, 20, 3};

    reset    = 1'b1;
    rif.ctrl = 1'b0;
    rif.echo = 1'b0;
    repeat (3) tick();
    check("reset trigger", rif.trigger, 0);
    check("reset distance_output", rif.distance_output, 0);
    check("reset distance_cm", rif.distance_cm, 0);
    check("reset distance_valid", rif.distance_valid, 0);
    reset = 1'b0;
    repeat (5) tick();
    check("idle trigger", rif.trigger, 0);

    // Trigger pulse shape from IDLE.
    rif.ctrl = 1'b1;
    tick();
    check("trigger rise latency", rif.trigger, 1);
    len = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!rif.trigger) break;
      len++;
    end
    check("trigger width", len, TRIG);
    rif.ctrl = 1'b0;
    repeat (2) tick();

    // Timeout with no echo edge at all.
    start_shot();
    wait_for("no-echo valid", 1'b1, 1'b1, 500, n);
    check("no-echo timeout latency", n, TO);
    check("no-echo cm", rif.distance_cm, 511);
    check("no-echo bin", rif.distance_output, 0);
    tick();
    check("no-echo valid width", rif.distance_valid, 0);
    rif.ctrl = 1'b0;
    repeat (2) tick();

    // Echo stuck high past the timeout.
    start_shot();
    tick();
    rif.echo = 1'b1;
    wait_for("stuck valid", 1'b1, 1'b1, 600, n);
    check("stuck timeout latency", n, TO + 2);
    check("stuck cm", rif.distance_cm, 511);
    check("stuck bin", rif.distance_output, 0);
    rif.echo = 1'b0;
    tick();
    check("stuck valid width", rif.distance_valid, 0);
    rif.ctrl = 1'b0;
    repeat (4) tick();

    for (int i = 0; i < 9; i++) begin
      start_shot();
      repeat (2) tick();
      rif.echo = 1'b1;
      repeat (vecs[i].len) tick();
      rif.echo = 1'b0;
      wait_for($sformatf("vec%0d valid", i), 1'b1, 1'b1, 20, n);
      check($sformatf("vec%0d cm", i), rif.distance_cm, vecs[i].exp_cm);
      check($sformatf("vec%0d bin", i), rif.distance_output, vecs[i].exp_bin);
      tick();
      check($sformatf("vec%0d valid width", i), rif.distance_valid, 0);
      rif.ctrl = 1'b0;
      repeat (2) tick();
    end

    // Abort mid-MEASURE keeps the previous bin-3 result.
    start_shot();
    tick();
    rif.echo = 1'b1;
    repeat (20) tick();
    rif.ctrl = 1'b0;
    tick();
    check("abort trigger", rif.trigger, 0);
    rif.echo = 1'b0;
    vcnt = 0;
    tcnt = 0;
    repeat (60) begin
      tick();
      if (rif.distance_valid) vcnt++;
      if (rif.trigger) tcnt++;
    end
    check("abort valid pulses", vcnt, 0);
    check("abort trigger pulses", tcnt, 0);
    check("abort bin hold", rif.distance_output, 3);
    check("abort cm hold", rif.distance_cm, 20);
    rif.ctrl = 1'b1;
    tick();
    check("restart trigger rise", rif.trigger, 1);
    len = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!rif.trigger) break;
      len++;
    end
    check("restart trigger width", len, TRIG);
    rif.ctrl = 1'b0;
    repeat (2) tick();

    // Continuous mode: holdoff spacing, then a stale-high echo on the next shot.
    start_shot();
    repeat (2) tick();
    rif.echo = 1'b1;
    repeat (60) tick();
    rif.echo = 1'b0;
    wait_for("cont valid", 1'b1, 1'b1, 20, n);
    check("cont cm", rif.distance_cm, 15);
    check("cont bin", rif.distance_output, 2);
    wait_for("cont retrigger", 1'b0, 1'b1, 100, n);
    check("holdoff to trigger", n, HO + 1);
    rif.echo = 1'b1;
    wait_for("stale trigger fall", 1'b0, 1'b0, 20, n);
    vcnt = 0;
    repeat (30) begin
      tick();
      if (rif.distance_valid) vcnt++;
    end
    check("stale no result", vcnt, 0);
    rif.echo = 1'b0;
    repeat (5) tick();
    rif.echo = 1'b1;
    repeat (28) tick();
    rif.echo = 1'b0;
    wait_for("stale valid", 1'b1, 1'b1, 20, n);
    check("stale cm", rif.distance_cm, 7);
    check("stale bin", rif.distance_output, 1);

    // Reset in the middle of the next trigger pulse.
    wait_for("pre-reset trigger", 1'b0, 1'b1, 100, n);
    tick();
    reset = 1'b1;
    tick();
    check("midreset trigger", rif.trigger, 0);
    check("midreset cm", rif.distance_cm, 0);
    check("midreset bin", rif.distance_output, 0);
    check("midreset valid", rif.distance_valid, 0);
    reset    = 1'b0;
    rif.ctrl = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
Drives an HC-SR04-style ultrasonic sensor: issues the trigger pulse, times the echo pulse, converts it to centimetres and quantises it to a 3-bit distance bin. It sits directly upstream of the stop-state controller, which enables it via ctrl and reads distance_output before sending an ASCII digit over UART. While ctrl is high it measures continuously, with a fixed holdoff between shots.

Parameters:
TRIG_CYCLES, 1000, trigger high time in clk cycles (10 us at 100 MHz)
CYCLES_PER_CM, 5800, echo-high clk cycles per centimetre (58 us/cm at 100 MHz)
TIMEOUT_CYCLES, 3000000, max wait for the echo rising edge, and max echo-high time (30 ms)
HOLDOFF_CYCLES, 6000000, idle gap after each result before the next trigger (60 ms)
TH1_CM, 10, upper bound (exclusive) of bin 1
TH2_CM, 20, upper bound (exclusive) of bin 2
TH3_CM, 30, upper bound (exclusive) of bin 3
TH4_CM, 40, upper bound (exclusive) of bin 4

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ctrl  in  1  measurement enable from the controller
echo  in  1  asynchronous echo line from the sensor
trigger  out  1  registered trigger pulse to the sensor
distance_output  out  3  bin code: 0 = none or out of range, 1..4 = bins
distance_cm  out  9  last measured distance in cm, saturating at 511
distance_valid  out  1  one-cycle pulse when a new result is loaded

Behaviour:
- Reset and clock: reset is synchronous, active-high; clock is clk.
- Reset values: trigger=0, distance_output=0, distance_cm=0, distance_valid=0, state=IDLE, all counters 0.
- Echo input: passes through a 2-FF synchroniser with rise/fall detection on the synchronised signal. This adds a fixed 2-cycle latency that cancels in the width measurement.
- IDLE:
  - trigger=0.
  - If ctrl=1, go to TRIG; trigger goes high on the next cycle.
- TRIG:
  - trigger=1 for exactly TRIG_CYCLES cycles, then go to WAIT_ECHO with trigger=0.
- WAIT_ECHO:
  - Waits for a rising edge of the synchronised echo.
  - If echo is already high on entry (stale), it must fall first; a level is never accepted in place of an edge.
  - Rising edge → MEASURE, with the cycle counter and cm counter cleared.
  - TIMEOUT_CYCLES elapse with no edge → result = timeout.
- MEASURE, while the synchronised echo is high:
  - A sub-counter counts 0..CYCLES_PER_CM-1; on wrap, the cm counter increments, saturating at 511. No divider is used.
  - Falling edge → result = cm counter.
  - Echo high for TIMEOUT_CYCLES → result = timeout.
- Result load:
  - Happens the cycle after the falling edge or timeout.
  - distance_cm = measured cm, or 511 on timeout.
  - distance_output: cm<TH1 → 1; TH1≤cm<TH2 → 2; TH2≤cm<TH3 → 3; TH3≤cm<TH4 → 4; cm≥TH4 or timeout → 0.
  - distance_valid=1 for exactly one cycle; then go to HOLDOFF.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES, then goes to TRIG if ctrl=1, else IDLE.
- Output hold: distance_output and distance_cm hold their values until the next result load; they are never cleared by ctrl.
- ctrl deasserted in TRIG, WAIT_ECHO, MEASURE or HOLDOFF:
  - Abort to IDLE on the next cycle.
  - trigger drops that cycle; no distance_valid pulse; outputs keep their previous values.
- ctrl re-asserted after an abort: a full new cycle starts with TRIG.
- Reset mid-operation: overrides everything; all outputs return to their reset values on the next edge.
- Counter widths: $clog2 of the largest cycle parameter, +1; no counter may wrap silently.

Decomposition:
- Package ultrasonic_pkg holds:
  - state enum ranger_state_t {IDLE, TRIG, WAIT_ECHO, MEASURE, HOLDOFF};
  - distance codes DIST_NONE=3'd0 through DIST_BIN4=3'd4;
  - CM_MAX=9'd511.
- Sub-module echo_sync: 2-FF synchroniser plus rise/fall pulse outputs. Instantiated once.

Test Plan:
All scenarios use TRIG_CYCLES=5, CYCLES_PER_CM=4, TIMEOUT_CYCLES=400, HOLDOFF_CYCLES=50 and the default thresholds.
1. Reset, then ctrl=1 → trigger high for exactly 5 cycles starting 1 cycle after ctrl is sampled; all outputs 0 before this.
2. echo high 60 cycles → distance_cm=15, distance_output=2, distance_valid high exactly 1 cycle.
3. Boundaries: echo high 40 cycles → cm=10, bin 2; echo high 39 cycles → cm=9, bin 1; echo high 160 cycles → cm=40, bin 0.
4. Timeouts: no echo edge for 400 cycles → distance_cm=511, distance_output=0, one valid pulse. Echo stuck high 400+ cycles → same result.
5. Abort: ctrl dropped mid-MEASURE after a previous result of bin 3 → IDLE next cycle, trigger=0, no valid pulse, distance_output stays 3.
6. Continuous: ctrl held high → next trigger rises exactly 51 cycles after the valid pulse. Echo already high when WAIT_ECHO is entered → no measurement until echo falls and rises again.
